// File: rtl/rotary_encoder_conditioner.sv
// Synchronizes and debounces the Pmod ENC A/B/switch pins, emitting clean levels and one-cycle edge strobes.
// Latency: DEBOUNCE_CYCLES+1 edges from first capture of a stable raw value; no backpressure, all outputs registered.
module rotary_encoder_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    input  logic sw_raw,
    output logic a,
    output logic b,
    output logic sw,
    output logic a_rise,
    output logic a_fall,
    output logic sw_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam int CH_A  = 0;
    localparam int CH_B  = 1;
    localparam int CH_SW = 2;
    // A and B idle high on the connector, the switch idles low.
    localparam logic [2:0] RST_LVL = 3'b011;

    logic [2:0]    raw;
    logic [2:0]    s1_q;
    logic [2:0]    s2_q;
    logic [2:0]    clean_q;
    logic [2:0]    clean_d;
    logic [2:0]    upd;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic          a_rise_q, a_rise_d;
    logic          a_fall_q, a_fall_d;
    logic          sw_press_q, sw_press_d;

    assign raw = {sw_raw, b_raw, a_raw};

    always_comb begin
        clean_d = clean_q;
        upd     = '0;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    clean_d[i] = s2_q[i];
                    upd[i]     = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        // Strobes are registered alongside the clean level so both change on the same edge.
        a_rise_d   = upd[CH_A]  &  s2_q[CH_A];
        a_fall_d   = upd[CH_A]  & ~s2_q[CH_A];
        sw_press_d = upd[CH_SW] &  s2_q[CH_SW];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q       <= RST_LVL;
            s2_q       <= RST_LVL;
            clean_q    <= RST_LVL;
            a_rise_q   <= 1'b0;
            a_fall_q   <= 1'b0;
            sw_press_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q       <= raw;
            s2_q       <= s1_q;
            clean_q    <= clean_d;
            a_rise_q   <= a_rise_d;
            a_fall_q   <= a_fall_d;
            sw_press_q <= sw_press_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign a        = clean_q[CH_A];
    assign b        = clean_q[CH_B];
    assign sw       = clean_q[CH_SW];
    assign a_rise   = a_rise_q;
    assign a_fall   = a_fall_q;
    assign sw_press = sw_press_q;

endmodule

// File: tb/tb_rotary_encoder_conditioner.sv
// Directed bench for rotary_encoder_conditioner: main instance at DEBOUNCE_CYCLES=4, second at 1.
module tb_rotary_encoder_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic a_raw, b_raw, sw_raw;
    logic a, b, sw, a_rise, a_fall, sw_press;
    logic a_raw1, b_raw1, sw_raw1;
    logic a1, b1, sw1, a_rise1, a_fall1, sw_press1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rotary_encoder_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .a_raw(a_raw), .b_raw(b_raw), .sw_raw(sw_raw),
        .a(a), .b(b), .sw(sw),
        .a_rise(a_rise), .a_fall(a_fall), .sw_press(sw_press)
    );

    rotary_encoder_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .a_raw(a_raw1), .b_raw(b_raw1), .sw_raw(sw_raw1),
        .a(a1), .b(b1), .sw(sw1),
        .a_rise(a_rise1), .a_fall(a_fall1), .sw_press(sw_press1)
    );

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        a_raw = 1'b1; b_raw = 1'b1; sw_raw = 1'b0;
        a_raw1 = 1'b1; b_raw1 = 1'b1; sw_raw1 = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        logic [5:0] got;
        reset = 1'b1;
        a_raw = 1'b1; b_raw = 1'b1; sw_raw = 1'b0;
        a_raw1 = 1'b1; b_raw1 = 1'b1; sw_raw1 = 1'b0;
        step(); step();
        got = {a, b, sw, a_rise, a_fall, sw_press};
        n_vec++;
        if (got !== 6'b110000) begin
            n_err++;
            $display("FAIL reset_held: got %b expected %b", got, 6'b110000);
        end
        reset = 1'b0;
        for (int e = 0; e < 20; e++) begin
            step();
            got = {a, b, sw, a_rise, a_fall, sw_press};
            n_vec++;
            if (got !== 6'b110000) begin
                n_err++;
                $display("FAIL reset_idle edge %0d: got %b expected %b", e, got, 6'b110000);
            end
            got = {a1, b1, sw1, a_rise1, a_fall1, sw_press1};
            n_vec++;
            if (got !== 6'b110000) begin
                n_err++;
                $display("FAIL reset_idle_d1 edge %0d: got %b expected %b", e, got, 6'b110000);
            end
        end
    endtask

    // Raw A goes low before edge 0 and back high before edge 10.
    task automatic test_clean_step();
        logic [4:0] got, exp;
        for (int e = 0; e < 18; e++) begin
            a_raw = (e < 10) ? 1'b0 : 1'b1;
            step();
            exp = {((e >= 5) && (e < 15)) ? 1'b0 : 1'b1, 1'b1, 1'b0, e == 15, e == 5};
            got = {a, b, sw, a_rise, a_fall};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL clean_step edge %0d: got %b expected %b", e, got, exp);
            end
        end
        idle(4);
    endtask

    task automatic test_glitch();
        logic [2:0] got, exp;
        // 3-cycle low pulse: one short of the debounce count.
        for (int e = 0; e < 12; e++) begin
            a_raw = (e < 3) ? 1'b0 : 1'b1;
            step();
            got = {a, a_rise, a_fall};
            n_vec++;
            if (got !== 3'b100) begin
                n_err++;
                $display("FAIL glitch_short edge %0d: got %b expected %b", e, got, 3'b100);
            end
        end
        // 4-cycle low pulse: just long enough to pass.
        for (int e = 0; e < 14; e++) begin
            a_raw = (e < 4) ? 1'b0 : 1'b1;
            step();
            exp = {((e >= 5) && (e < 9)) ? 1'b0 : 1'b1, e == 9, e == 5};
            got = {a, a_rise, a_fall};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL glitch_pass edge %0d: got %b expected %b", e, got, exp);
            end
        end
        idle(4);
    endtask

    // B alternates 0/1 for edges 0..9, settles low from edge 10 (last s1 change), back high at 21.
    task automatic test_bounce();
        logic [2:0] got, exp;
        for (int e = 0; e < 29; e++) begin
            if (e < 10)      b_raw = (e % 2 == 0) ? 1'b0 : 1'b1;
            else if (e < 21) b_raw = 1'b0;
            else             b_raw = 1'b1;
            step();
            exp = {((e >= 15) && (e < 26)) ? 1'b0 : 1'b1, 1'b1, 1'b0};
            got = {b, a, a_fall};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL bounce edge %0d: got %b expected %b", e, got, exp);
            end
        end
        idle(4);
    endtask

    task automatic test_simultaneous();
        logic [5:0] got, exp;
        for (int e = 0; e < 20; e++) begin
            a_raw  = (e < 10) ? 1'b0 : 1'b1;
            b_raw  = (e < 10) ? 1'b0 : 1'b1;
            sw_raw = (e < 10) ? 1'b1 : 1'b0;
            step();
            if (e < 5)       exp = 6'b110000;
            else if (e == 5) exp = 6'b001011;
            else if (e < 15) exp = 6'b001000;
            else if (e == 15) exp = 6'b110100;
            else             exp = 6'b110000;
            got = {a, b, sw, a_rise, a_fall, sw_press};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL simultaneous edge %0d: got %b expected %b", e, got, exp);
            end
        end
        idle(4);
    endtask

    task automatic test_reset_mid();
        logic [2:0] got, exp;
        a_raw = 1'b0;
        for (int e = 0; e < 3; e++) step();
        reset = 1'b1;
        #1;
        got = {a, a_rise, a_fall};
        n_vec++;
        if (got !== 3'b100) begin
            n_err++;
            $display("FAIL reset_mid_assert: got %b expected %b", got, 3'b100);
        end
        step(); step();
        got = {a, a_rise, a_fall};
        n_vec++;
        if (got !== 3'b100) begin
            n_err++;
            $display("FAIL reset_mid_held: got %b expected %b", got, 3'b100);
        end
        reset = 1'b0;
        // Edge 0 is the first edge after release, where s1 recaptures the low pin.
        for (int e = 0; e < 9; e++) begin
            step();
            exp = {(e >= 5) ? 1'b0 : 1'b1, 1'b0, e == 5};
            got = {a, a_rise, a_fall};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL reset_mid_recount edge %0d: got %b expected %b", e, got, exp);
            end
        end
        idle(8);
    endtask

    task automatic test_d1();
        logic [2:0] got, exp;
        for (int e = 0; e < 10; e++) begin
            a_raw1 = (e < 5) ? 1'b0 : 1'b1;
            step();
            exp = {((e >= 2) && (e < 7)) ? 1'b0 : 1'b1, e == 7, e == 2};
            got = {a1, a_rise1, a_fall1};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL d1_step edge %0d: got %b expected %b", e, got, exp);
            end
        end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_d1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
